sprite_tex_loader: RTL and testbench
====================================

Name: sprite_tex_loader

Overview:
Parametrised texture-load sequencer in the bird_load_clk domain, between the SDRAM/SD pixel stream and the sprite texture RAMs. It walks NUM_CH channel descriptors in order and consumes each channel's full source image from a valid/ready stream. For each channel it crops to a stored window and emits one-hot RAM write strobes with packed addresses. It generalises the per-sprite fixed address filters (bird/pipe/base) into one descriptor-driven block with cropping, skipping, abort and completion status.

Parameters:
NUM_CH, 3, number of texture channels/destination RAMs
DATA_W, 16, pixel width (RGB565)
DIM_W, 10, width of width/height descriptor fields
ADDR_W, 16, destination write address width

Ports:
bird_load_clk  in  1  load clock (50 MHz)
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a load pass
abort  in  1  one-cycle pulse; terminates pass
ch_enable  in  NUM_CH  per-channel enable
ch_src_w  in  NUM_CH*DIM_W  source image width, channel k at [k*DIM_W +: DIM_W]
ch_src_h  in  NUM_CH*DIM_W  source image height
ch_crop_w  in  NUM_CH*DIM_W  stored width
ch_crop_h  in  NUM_CH*DIM_W  stored rows
ch_base  in  NUM_CH*ADDR_W  destination base address
in_valid  in  1  stream pixel valid
in_data  in  DATA_W  stream pixel
in_ready  out  1  stream ready
wr_en  out  1  RAM write strobe
wr_sel  out  NUM_CH  one-hot destination select
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
busy  out  1  pass in progress
done  out  1  one-cycle pulse at normal completion
ch_loaded  out  NUM_CH  sticky per-channel complete flags
cur_ch  out  2  channel index being streamed

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Counters 0. ch_loaded cleared.
- States: IDLE, SETUP, STREAM, NEXT, FIN.
- IDLE: on start -> SETUP with ch_idx=0, ch_loaded cleared. busy=1 from the cycle after start until the cycle after FIN. start while busy is ignored.
- SETUP (1 cycle): latch descriptor k.
  - eff_w = min(crop_w, src_w); eff_h = min(crop_h, src_h).
  - col=row=0; row_base=ch_base.
  - If !ch_enable[k], src_w==0 or src_h==0 -> NEXT without setting ch_loaded[k]. Otherwise -> STREAM.
- STREAM: in_ready=1. A beat is accepted when in_valid && in_ready.
  - If col<eff_w && row<eff_h, the beat is written: registered 1 cycle later with wr_en=1, wr_sel=1<<k, wr_addr=row_base+col, wr_data=beat. Otherwise the beat is consumed, no write.
  - col increments per beat. At col==src_w-1: col=0, row+1, row_base+=eff_w. No multiplier.
  - Accepting the beat at row==src_h-1 && col==src_w-1 sets ch_loaded[k] -> NEXT; in_ready drops the next cycle.
- NEXT: k==NUM_CH-1 -> FIN, else k+1 -> SETUP.
- FIN: done=1 for exactly one cycle -> IDLE.
- Address arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W. No clamping.
- abort in any non-IDLE state: -> IDLE next cycle. in_ready deasserts that cycle. A write registered from a beat accepted in the abort cycle is suppressed. done is not pulsed. ch_loaded keeps completed channels.
- abort and start together in IDLE: abort wins, no pass begins.
- in_valid gaps: counters hold. No timeout.
- cur_ch = ch_idx while busy, else 0.
- Asynchronous reset mid-pass: immediate return to the reset state.

Decomposition:
- Shared package sprite_pkg:
  - FSM state encoding.
  - Default descriptors: bird 50x105, crop 50x105, base 0. Pipe 80x500, crop 80x50. Ground 64x150, crop 32x150.
  - TRANSPARENT_COLOR 16'h07E0.
- Sub-module tex_addr_gen: col/row counters, row_base accumulator, in-window compare, last-pixel flag. Inputs: eff_w, eff_h, src_w, src_h, base, load, step.

Test Plan:
- Bird-like channel only (ch_enable=001), 50x105, crop 50x105, base 0, continuous valid: 5250 writes, addr 0..5249, wr_sel=001. done pulses 1 cycle after NEXT. ch_loaded=001.
- Pipe-like channel 80x500, crop 80x50, base 0: 40000 beats accepted, exactly 4000 writes. Last write addr 3999 = beat 3999. Beats 4000..39999 produce no wr_en.
- Ground-like channel 64x150, crop 32x150, base 100: pixel (row 2, col 5) -> addr 169. Cols 32..63 never written. 4800 writes total.
- All three channels enabled, random in_valid (50% duty): channels written in order 0,1,2. No beat lost or duplicated. Data matches the source sequence.
- Channel 1 disabled, channel 2 with src_w=0: both skipped with zero beats consumed. ch_loaded=001.
- abort after 1000 beats of channel 1: busy=0 within 2 cycles, no write after abort cycle, no done, ch_loaded=001. A fresh start then reloads from channel 0 and clears ch_loaded.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared loader state encoding and default sprite texture descriptors.
package sprite_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, STREAM, NEXT, FIN} state_t;
    localparam int BIRD_SRC_W = 50;
    localparam int BIRD_SRC_H = 105;
    localparam int BIRD_CROP_W = 50;
    localparam int BIRD_CROP_H = 105;
    localparam int BIRD_BASE = 0;
    localparam int PIPE_SRC_W = 80;
    localparam int PIPE_SRC_H = 500;
    localparam int PIPE_CROP_W = 80;
    localparam int PIPE_CROP_H = 50;
    localparam int PIPE_BASE = 0;
    localparam int GROUND_SRC_W = 64;
    localparam int GROUND_SRC_H = 150;
    localparam int GROUND_CROP_W = 32;
    localparam int GROUND_CROP_H = 150;
    localparam int GROUND_BASE = 0;
    localparam logic [15:0] TRANSPARENT_COLOR = 16'h07E0;
endpackage

// File: rtl/sprite_tex_if.sv
// sprite_tex_if: pixel stream in and texture RAM write bus out of the loader.
interface sprite_tex_if #(parameter int NUM_CH = 3, parameter int DATA_W = 16, parameter int ADDR_W = 16);
    logic in_valid;
    logic [DATA_W-1:0] in_data;
    logic in_ready;
    logic wr_en;
    logic [NUM_CH-1:0] wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    modport master (output in_valid, in_data, input in_ready, wr_en, wr_sel, wr_addr, wr_data);
    modport slave (input in_valid, in_data, output in_ready, wr_en, wr_sel, wr_addr, wr_data);
endinterface

// File: rtl/tex_addr_gen.sv
// tex_addr_gen: column/row walk over the source image with crop-window test and packed row base.
module tex_addr_gen #(
    parameter int DIM_W = 10,
    parameter int ADDR_W = 16
) (
    input  logic              bird_load_clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DIM_W-1:0]  eff_w,
    input  logic [DIM_W-1:0]  eff_h,
    input  logic [DIM_W-1:0]  src_w,
    input  logic [DIM_W-1:0]  src_h,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr,
    output logic              in_win,
    output logic              last
);
    logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
    logic [DIM_W-1:0] ew_q, ew_d, eh_q, eh_d, sw_q, sw_d, sh_q, sh_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic eol;

    always_ff @(posedge bird_load_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            ew_q <= '0;
            eh_q <= '0;
            sw_q <= '0;
            sh_q <= '0;
            row_base_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            ew_q <= ew_d;
            eh_q <= eh_d;
            sw_q <= sw_d;
            sh_q <= sh_d;
            row_base_q <= row_base_d;
        end
    end

    // row_base advances by the stored width so the RAM image is packed without a multiplier
    always_comb begin
        eol = col_q == sw_q - 1'b1;
        col_d = load ? '0 : step ? (eol ? '0 : col_q + 1'b1) : col_q;
        row_d = load ? '0 : (step && eol) ? row_q + 1'b1 : row_q;
        row_base_d = load ? base : (step && eol) ? row_base_q + ADDR_W'(ew_q) : row_base_q;
        ew_d = load ? eff_w : ew_q;
        eh_d = load ? eff_h : eh_q;
        sw_d = load ? src_w : sw_q;
        sh_d = load ? src_h : sh_q;
    end

    assign addr = row_base_q + ADDR_W'(col_q);
    assign in_win = (col_q < ew_q) && (row_q < eh_q);
    assign last = eol && (row_q == sh_q - 1'b1);
endmodule

// File: rtl/sprite_tex_loader.sv
// sprite_tex_loader: walks channel descriptors, crops each streamed image and writes it to its texture RAM.
module sprite_tex_loader
    import sprite_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 16,
    parameter int DIM_W = 10,
    parameter int ADDR_W = 16
) (
    input  logic                     bird_load_clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH*DIM_W-1:0]  ch_src_w,
    input  logic [NUM_CH*DIM_W-1:0]  ch_src_h,
    input  logic [NUM_CH*DIM_W-1:0]  ch_crop_w,
    input  logic [NUM_CH*DIM_W-1:0]  ch_crop_h,
    input  logic [NUM_CH*ADDR_W-1:0] ch_base,
    sprite_tex_if.slave              bus,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH-1:0]        ch_loaded,
    output logic [1:0]               cur_ch
);
    state_t state_q, state_d;
    logic [1:0] ch_idx_q, ch_idx_d;
    logic [NUM_CH-1:0] ch_loaded_q, ch_loaded_d;
    logic wr_en_q, wr_en_d;
    logic [NUM_CH-1:0] wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DIM_W-1:0] src_w, src_h, crop_w, crop_h, eff_w, eff_h;
    logic [ADDR_W-1:0] base, gen_addr;
    logic skip, accept, in_win, last;

    assign src_w = ch_src_w[ch_idx_q*DIM_W +: DIM_W];
    assign src_h = ch_src_h[ch_idx_q*DIM_W +: DIM_W];
    assign crop_w = ch_crop_w[ch_idx_q*DIM_W +: DIM_W];
    assign crop_h = ch_crop_h[ch_idx_q*DIM_W +: DIM_W];
    assign base = ch_base[ch_idx_q*ADDR_W +: ADDR_W];
    assign eff_w = crop_w < src_w ? crop_w : src_w;
    assign eff_h = crop_h < src_h ? crop_h : src_h;
    assign skip = !ch_enable[ch_idx_q] || src_w == '0 || src_h == '0;

    tex_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_addr_gen (
        .bird_load_clk(bird_load_clk),
        .rst_n(rst_n),
        .load(state_q == SETUP),
        .step(accept),
        .eff_w(eff_w),
        .eff_h(eff_h),
        .src_w(src_w),
        .src_h(src_h),
        .base(base),
        .addr(gen_addr),
        .in_win(in_win),
        .last(last)
    );

    always_ff @(posedge bird_load_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_idx_q <= '0;
            ch_loaded_q <= '0;
            wr_en_q <= 1'b0;
            wr_sel_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            ch_idx_q <= ch_idx_d;
            ch_loaded_q <= ch_loaded_d;
            wr_en_q <= wr_en_d;
            wr_sel_q <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // abort beats every state but IDLE, where it also masks a simultaneous start
    always_comb begin
        state_d = state_q;
        ch_idx_d = ch_idx_q;
        ch_loaded_d = ch_loaded_q;
        if (state_q == IDLE) begin
            if (start && !abort) begin
                state_d = SETUP;
                ch_idx_d = '0;
                ch_loaded_d = '0;
            end
        end else if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                SETUP: state_d = skip ? NEXT : STREAM;
                STREAM: begin
                    if (accept && last) begin
                        state_d = NEXT;
                        ch_loaded_d[ch_idx_q] = 1'b1;
                    end
                end
                NEXT: begin
                    if (ch_idx_q == 2'(NUM_CH - 1)) begin
                        state_d = FIN;
                    end else begin
                        state_d = SETUP;
                        ch_idx_d = ch_idx_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = state_q == STREAM && !abort;
        accept = bus.in_valid && bus.in_ready;
        wr_en_d = accept && in_win;
        wr_sel_d = wr_en_d ? NUM_CH'(1) << ch_idx_q : '0;
        wr_addr_d = wr_en_d ? gen_addr : wr_addr_q;
        wr_data_d = wr_en_d ? bus.in_data : wr_data_q;
    end

    assign bus.wr_en = wr_en_q;
    assign bus.wr_sel = wr_sel_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy = state_q != IDLE;
    assign done = state_q == FIN;
    assign ch_loaded = ch_loaded_q;
    assign cur_ch = busy ? ch_idx_q : 2'd0;
endmodule

// File: tb/tb_sprite_tex_loader.sv
// tb_sprite_tex_loader: directed scenarios against a cropped-image write model.
module tb_sprite_tex_loader;
    import sprite_pkg::*;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 16;
    localparam int DIM_W = 10;
    localparam int ADDR_W = 16;

    typedef struct packed {
        logic [NUM_CH-1:0] sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [NUM_CH-1:0] ch_enable = '0;
    logic [NUM_CH*DIM_W-1:0] ch_src_w = '0, ch_src_h = '0, ch_crop_w = '0, ch_crop_h = '0;
    logic [NUM_CH*ADDR_W-1:0] ch_base = '0;
    logic busy, done;
    logic [NUM_CH-1:0] ch_loaded;
    logic [1:0] cur_ch;

    int checks = 0;
    int errors = 0;
    int src_seq = 0;
    int mseq = 0;
    wr_t got[$];
    wr_t exp_q[$];
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, busy_fall_cyc = 0, ready_cnt = 0;
    logic busy_prev = 1'b0;

    sprite_tex_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sprite_tex_loader #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
        .bird_load_clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .ch_enable(ch_enable),
        .ch_src_w(ch_src_w),
        .ch_src_h(ch_src_h),
        .ch_crop_w(ch_crop_w),
        .ch_crop_h(ch_crop_h),
        .ch_base(ch_base),
        .bus(bus),
        .busy(busy),
        .done(done),
        .ch_loaded(ch_loaded),
        .cur_ch(cur_ch)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.wr_en) begin
            got.push_back({bus.wr_sel, bus.wr_addr, bus.wr_data});
            last_wr_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy_prev && !busy) busy_fall_cyc <= cyc;
        if (bus.in_ready) ready_cnt <= ready_cnt + 1;
        busy_prev <= busy;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_ch(input int k, input bit en, input int sw, input int sh, input int cw, input int chh, input int base);
        ch_enable[k] = en;
        ch_src_w[k*DIM_W +: DIM_W] = DIM_W'(sw);
        ch_src_h[k*DIM_W +: DIM_W] = DIM_W'(sh);
        ch_crop_w[k*DIM_W +: DIM_W] = DIM_W'(cw);
        ch_crop_h[k*DIM_W +: DIM_W] = DIM_W'(chh);
        ch_base[k*ADDR_W +: ADDR_W] = ADDR_W'(base);
    endtask

    task automatic model(input int k, input int sw, input int sh, input int cw, input int chh, input int base, input int limit);
        int ew, eh, r, c;
        wr_t w;
        ew = cw < sw ? cw : sw;
        eh = chh < sh ? chh : sh;
        for (int i = 0; i < sw * sh && i < limit; i++) begin
            r = i / sw;
            c = i % sw;
            if (c < ew && r < eh) begin
                w.sel = NUM_CH'(1 << k);
                w.addr = ADDR_W'(base + r * ew + c);
                w.data = DATA_W'(mseq);
                exp_q.push_back(w);
            end
            mseq++;
        end
    endtask

    function automatic int first_mm(input int gb);
        for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++)
            if (got[gb+i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic pulse_start;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic feed(input int n, input bit rnd, input string nm);
        int sent = 0;
        int guard = 0;
        bit acc;
        while (sent < n && guard < 4 * n + 1000) begin
            bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data = DATA_W'(src_seq);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                src_seq++;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (sent != n) begin
            errors++;
            $display("FAIL %s feed: accepted %0d beats, required %0d", nm, sent, n);
        end
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        while (busy && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b after %0d cycles, required 0", nm, busy, g);
        end
    endtask

    task automatic check_pass(input string nm, input int gb, input int db, input logic [NUM_CH-1:0] loaded, input int ndone);
        int mm;
        checks++;
        if (got.size() - gb != exp_q.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d, required %0d", nm, got.size() - gb, exp_q.size());
        end
        mm = first_mm(gb);
        checks++;
        if (mm != -1) begin
            errors++;
            $display("FAIL %s write %0d: got %h, required %h", nm, mm, got[gb+mm], exp_q[mm]);
        end
        checks++;
        if (ch_loaded !== loaded) begin
            errors++;
            $display("FAIL %s ch_loaded: got %b, required %b", nm, ch_loaded, loaded);
        end
        checks++;
        if (done_cnt - db != ndone) begin
            errors++;
            $display("FAIL %s done pulses: got %0d, required %0d", nm, done_cnt - db, ndone);
        end
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, ch_loaded, cur_ch, bus.in_ready, bus.wr_en, bus.wr_sel, bus.wr_addr, bus.wr_data} !== '0) begin
            errors++;
            $display("FAIL reset outputs: busy=%b done=%b loaded=%b cur=%0d rdy=%b wr_en=%b sel=%b addr=%h data=%h, required all 0",
                     busy, done, ch_loaded, cur_ch, bus.in_ready, bus.wr_en, bus.wr_sel, bus.wr_addr, bus.wr_data);
        end
        rst_n = 1'b1;
        set_ch(0, 1'b1, 4, 3, 4, 3, 0);
        @(posedge clk);
        #1 start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_abort busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_bird;
        int gb = got.size();
        int db = done_cnt;
        exp_q.delete();
        src_seq = 1000;
        mseq = 1000;
        set_ch(0, 1'b1, BIRD_SRC_W, BIRD_SRC_H, BIRD_CROP_W, BIRD_CROP_H, BIRD_BASE);
        set_ch(1, 1'b0, 0, 0, 0, 0, 0);
        set_ch(2, 1'b0, 0, 0, 0, 0, 0);
        model(0, BIRD_SRC_W, BIRD_SRC_H, BIRD_CROP_W, BIRD_CROP_H, BIRD_BASE, 1 << 30);
        pulse_start;
        checks++;
        if (busy !== 1'b1 || cur_ch !== 2'd0) begin
            errors++;
            $display("FAIL bird busy after start: busy=%b cur_ch=%0d, required 1/0", busy, cur_ch);
        end
        feed(5250, 1'b0, "bird");
        wait_idle("bird");
        check_pass("bird", gb, db, 3'b001, 1);
        checks++;
        if (got.size() > gb && got[got.size()-1].addr !== 16'd5249) begin
            errors++;
            $display("FAIL bird last addr: got %0d, required 5249", got[got.size()-1].addr);
        end
        checks++;
        if (done_cyc - last_wr_cyc != 5) begin
            errors++;
            $display("FAIL bird done latency: got %0d cycles after last write, required 5", done_cyc - last_wr_cyc);
        end
        checks++;
        if (busy_fall_cyc - done_cyc != 1) begin
            errors++;
            $display("FAIL bird busy fall: got %0d cycles after done, required 1", busy_fall_cyc - done_cyc);
        end
    endtask

    task automatic test_pipe_crop;
        int gb = got.size();
        int db = done_cnt;
        exp_q.delete();
        src_seq = 0;
        mseq = 0;
        set_ch(0, 1'b1, PIPE_SRC_W, PIPE_SRC_H, PIPE_CROP_W, PIPE_CROP_H, PIPE_BASE);
        model(0, PIPE_SRC_W, PIPE_SRC_H, PIPE_CROP_W, PIPE_CROP_H, PIPE_BASE, 1 << 30);
        pulse_start;
        feed(40000, 1'b0, "pipe");
        wait_idle("pipe");
        check_pass("pipe", gb, db, 3'b001, 1);
        checks++;
        if (got.size() > gb && (got[got.size()-1].addr !== 16'd3999 || got[got.size()-1].data !== 16'd3999)) begin
            errors++;
            $display("FAIL pipe last write: addr=%0d data=%0d, required 3999/3999",
                     got[got.size()-1].addr, got[got.size()-1].data);
        end
    endtask

    task automatic test_ground_window;
        int gb = got.size();
        int db = done_cnt;
        int found = -1;
        int bad = 0;
        exp_q.delete();
        src_seq = 0;
        mseq = 0;
        set_ch(0, 1'b0, 0, 0, 0, 0, 0);
        set_ch(2, 1'b1, GROUND_SRC_W, GROUND_SRC_H, GROUND_CROP_W, GROUND_CROP_H, 100);
        model(2, GROUND_SRC_W, GROUND_SRC_H, GROUND_CROP_W, GROUND_CROP_H, 100, 1 << 30);
        pulse_start;
        feed(9600, 1'b0, "ground");
        wait_idle("ground");
        check_pass("ground", gb, db, 3'b100, 1);
        for (int i = gb; i < got.size(); i++) begin
            if (got[i].data == 16'd133) found = int'(got[i].addr);
            if (int'(got[i].data) % 64 >= 32) bad++;
        end
        checks++;
        if (found != 169) begin
            errors++;
            $display("FAIL ground pixel r2c5 addr: got %0d, required 169", found);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ground cropped cols: got %0d writes from cols 32..63, required 0", bad);
        end
    endtask

    task automatic test_all_random;
        int gb = got.size();
        int db = done_cnt;
        wr_t w;
        exp_q.delete();
        src_seq = 500;
        mseq = 500;
        set_ch(0, 1'b1, 6, 4, 4, 3, 10);
        set_ch(1, 1'b1, 5, 3, 9, 9, 65530);
        set_ch(2, 1'b1, 7, 2, 3, 5, 200);
        model(0, 6, 4, 4, 3, 10, 1 << 30);
        model(1, 5, 3, 9, 9, 65530, 1 << 30);
        model(2, 7, 2, 3, 5, 200, 1 << 30);
        pulse_start;
        feed(53, 1'b1, "all_random");
        wait_idle("all_random");
        check_pass("all_random", gb, db, 3'b111, 1);
        w = got.size() > gb + 18 ? got[gb+18] : '0;
        checks++;
        if (w !== {3'b010, 16'h0000, 16'd530}) begin
            errors++;
            $display("FAIL all_random addr wrap: got %h, required %h", w, {3'b010, 16'h0000, 16'd530});
        end
    endtask

    task automatic test_skip;
        int gb = got.size();
        int db = done_cnt;
        int rb = ready_cnt;
        exp_q.delete();
        src_seq = 0;
        mseq = 0;
        set_ch(0, 1'b1, 4, 3, 4, 3, 0);
        set_ch(1, 1'b0, 4, 3, 4, 3, 50);
        set_ch(2, 1'b1, 0, 3, 4, 3, 80);
        model(0, 4, 3, 4, 3, 0, 1 << 30);
        pulse_start;
        feed(12, 1'b0, "skip");
        wait_idle("skip");
        check_pass("skip", gb, db, 3'b001, 1);
        checks++;
        if (ready_cnt - rb != 12) begin
            errors++;
            $display("FAIL skip ready cycles: got %0d, required 12", ready_cnt - rb);
        end
    endtask

    task automatic test_abort;
        int gb = got.size();
        int db = done_cnt;
        exp_q.delete();
        src_seq = 0;
        mseq = 0;
        set_ch(0, 1'b1, 4, 3, 4, 3, 0);
        set_ch(1, 1'b1, 64, 150, 64, 150, 1000);
        set_ch(2, 1'b1, 4, 3, 4, 3, 0);
        model(0, 4, 3, 4, 3, 0, 1 << 30);
        model(1, 64, 150, 64, 150, 1000, 1000);
        pulse_start;
        feed(1012, 1'b0, "abort");
        abort = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort in_ready: got %b during abort, required 0", bus.in_ready);
        end
        @(posedge clk);
        #1 abort = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort busy: got %b one cycle after abort, required 0", busy);
        end
        repeat (4) @(posedge clk);
        #1;
        check_pass("abort", gb, db, 3'b001, 0);
        gb = got.size();
        db = done_cnt;
        exp_q.delete();
        src_seq = 0;
        mseq = 0;
        set_ch(1, 1'b1, 4, 3, 4, 3, 100);
        model(0, 4, 3, 4, 3, 0, 1 << 30);
        model(1, 4, 3, 4, 3, 100, 1 << 30);
        model(2, 4, 3, 4, 3, 0, 1 << 30);
        pulse_start;
        checks++;
        if (ch_loaded !== 3'b000 || cur_ch !== 2'd0) begin
            errors++;
            $display("FAIL restart clear: ch_loaded=%b cur_ch=%0d, required 000/0", ch_loaded, cur_ch);
        end
        feed(36, 1'b0, "restart");
        wait_idle("restart");
        check_pass("restart", gb, db, 3'b111, 1);
    endtask

    task automatic test_async_reset;
        set_ch(0, 1'b1, 64, 150, 64, 150, 0);
        pulse_start;
        feed(20, 1'b0, "async_reset");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, bus.wr_en, bus.in_ready, cur_ch, ch_loaded} !== '0) begin
            errors++;
            $display("FAIL async reset: busy=%b wr_en=%b rdy=%b cur=%0d loaded=%b, required all 0",
                     busy, bus.wr_en, bus.in_ready, cur_ch, ch_loaded);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_bird;
        test_pipe_crop;
        test_ground_window;
        test_all_random;
        test_skip;
        test_abort;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
